mips_writeback_regfile: RTL and testbench

Writeback stage and architectural register storage for the single-cycle MIPS datapath. It holds $t0–$t7 and $s0–$s7, and drives them onto the sixteen register outputs read by the decoder/register-read stage. It takes the completed instruction with its control bits and ALU result, selects the destination register, and performs the write. Loads are handled by waiting on a variable-latency data-memory response, stalling upstream through a valid/ready handshake, with a bounded timeout.

---
 rtl/mips_writeback_regfile.sv | 133 +++++++++++++
 tb/tb_mips_writeback_regfile.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_writeback_regfile.sv
// Writeback stage and $t0-$t7/$s0-$s7 register storage for the single-cycle MIPS datapath.
// ALU results retire in the accept cycle; loads park in WAIT_MEM until the memory
// response arrives or the load timeout expires.
module mips_writeback_regfile #(
    parameter int unsigned LOAD_TIMEOUT = 16,
    parameter logic [31:0] RETIRE_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [31:0] instruction,
    input  logic        RegW,
    input  logic        MemToReg,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [31:0] s0, s1, s2, s3, s4, s5, s6, s7,
    output logic [31:0] t0, t1, t2, t3, t4, t5, t6, t7,
    output logic        stall,
    output logic        wr_err,
    output logic [31:0] retire_count
);

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 5;
    localparam int unsigned CW  = 8;
    localparam int unsigned NREG = 16;

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [AW-1:0]   dest_q, dest_next, dest_c, wsel_c;
    logic [DW-1:0]   wdata_c;
    logic            we_c, retire_c, timeout_err_c;
    logic [DW-1:0]   regs [NREG];
    logic            unused_ok;

    // Destination decode: R-type writes rd, everything else writes rt
    assign dest_c = (instruction[31:26] == 6'b000000) ? instruction[15:11] : instruction[20:16];

    assign unused_ok = ^{instruction[25:21], instruction[10:0]};

    assign wb_ready = (state == IDLE);
    assign stall    = ~wb_ready;

    // State, timeout counter and latched load destination
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            dest_q <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            dest_q <= dest_next;
        end
    end

    // Next-state and write/retire control
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        dest_next     = dest_q;
        we_c          = 1'b0;
        wsel_c        = dest_q;
        wdata_c       = alu_result;
        retire_c      = 1'b0;
        timeout_err_c = 1'b0;
        case (state)
            IDLE: begin
                if (wb_valid) begin
                    if (RegW && MemToReg) begin
                        dest_next  = dest_c;
                        cnt_next   = '0;
                        state_next = WAIT_MEM;
                    end else begin
                        retire_c = 1'b1;
                        we_c     = RegW;
                        wsel_c   = dest_c;
                    end
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    we_c       = 1'b1;
                    wdata_c    = mem_rdata;
                    retire_c   = 1'b1;
                    state_next = IDLE;
                end else if (cnt == CW'(LOAD_TIMEOUT - 1)) begin
                    timeout_err_c = 1'b1;
                    retire_c      = 1'b1;
                    state_next    = IDLE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Register file write; register numbers 8..23 map onto storage slots 0..15
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we_c && wsel_c >= AW'(8) && wsel_c <= AW'(23)) begin
            regs[4'(wsel_c - AW'(8))] <= wdata_c;
        end
    end

    // Sticky error: unmapped nonzero destination or abandoned load
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err <= 1'b0;
        end else if (timeout_err_c ||
                     (we_c && wsel_c != '0 && (wsel_c < AW'(8) || wsel_c > AW'(23)))) begin
            wr_err <= 1'b1;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) retire_count <= RETIRE_RESET;
        else if (retire_c) retire_count <= retire_count + DW'(1);
    end

    assign t0 = regs[0];  assign t1 = regs[1];  assign t2 = regs[2];  assign t3 = regs[3];
    assign t4 = regs[4];  assign t5 = regs[5];  assign t6 = regs[6];  assign t7 = regs[7];
    assign s0 = regs[8];  assign s1 = regs[9];  assign s2 = regs[10]; assign s3 = regs[11];
    assign s4 = regs[12]; assign s5 = regs[13]; assign s6 = regs[14]; assign s7 = regs[15];

endmodule

// File: tb/tb_mips_writeback_regfile.sv
// Directed bench for mips_writeback_regfile: ALU writeback, load stall/timeout, error flag, reset, wrap.
module tb_mips_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst, wb_valid, wrap_valid, RegW, MemToReg, mem_rvalid;
    logic [31:0] instruction, alu_result, mem_rdata;
    logic        wb_ready, stall, wr_err;
    logic [31:0] retire_count;
    logic [31:0] t [8];
    logic [31:0] s [8];
    logic        w_ready, w_stall, w_err;
    logic [31:0] w_retire;
    logic [31:0] wt [8];
    logic [31:0] ws [8];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mips_writeback_regfile #(.LOAD_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .instruction(instruction), .RegW(RegW), .MemToReg(MemToReg),
        .alu_result(alu_result), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .s0(s[0]), .s1(s[1]), .s2(s[2]), .s3(s[3]), .s4(s[4]), .s5(s[5]), .s6(s[6]), .s7(s[7]),
        .t0(t[0]), .t1(t[1]), .t2(t[2]), .t3(t[3]), .t4(t[4]), .t5(t[5]), .t6(t[6]), .t7(t[7]),
        .stall(stall), .wr_err(wr_err), .retire_count(retire_count));

    // Second instance with the counter reset to all-ones to exercise wraparound
    mips_writeback_regfile #(.LOAD_TIMEOUT(16), .RETIRE_RESET(32'hFFFF_FFFF)) u_wrap (
        .clk(clk), .rst(rst), .wb_valid(wrap_valid), .wb_ready(w_ready),
        .instruction(instruction), .RegW(RegW), .MemToReg(MemToReg),
        .alu_result(alu_result), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .s0(ws[0]), .s1(ws[1]), .s2(ws[2]), .s3(ws[3]), .s4(ws[4]), .s5(ws[5]), .s6(ws[6]), .s7(ws[7]),
        .t0(wt[0]), .t1(wt[1]), .t2(wt[2]), .t3(wt[3]), .t4(wt[4]), .t5(wt[5]), .t6(wt[6]), .t7(wt[7]),
        .stall(w_stall), .wr_err(w_err), .retire_count(w_retire));

    function automatic logic [31:0] rtype(input logic [4:0] rd);
        return {6'b000000, 5'd1, 5'd2, rd, 11'd0};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt);
        return {op, 5'd1, rt, 16'h0004};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0; wrap_valid = 1'b0; RegW = 1'b0; MemToReg = 1'b0;
        mem_rvalid = 1'b0; instruction = '0; alu_result = '0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        #2;
        do_reset();
        repeat (3) tick();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("reset_t%0d", i), t[i], 32'h0);
            chk($sformatf("reset_s%0d", i), s[i], 32'h0);
        end
        chk("reset_ready", 32'(wb_ready), 32'h1);
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_err", 32'(wr_err), 32'h0);
        chk("reset_retire", retire_count, 32'h0);

        // R-type to $t1 then back-to-back I-type to $s1
        wb_valid = 1'b1; RegW = 1'b1; MemToReg = 1'b0;
        instruction = rtype(5'd9); alu_result = 32'h0000_0005;
        tick();
        chk("alu_t1", t[1], 32'h5);
        chk("alu_retire1", retire_count, 32'd1);
        chk("alu_ready_b2b", 32'(wb_ready), 32'h1);
        instruction = itype(6'h08, 5'd17); alu_result = 32'hDEAD_BEEF;
        tick();
        chk("alu_s1", s[1], 32'hDEAD_BEEF);
        chk("alu_retire2", retire_count, 32'd2);
        chk("alu_t1_hold", t[1], 32'h5);

        // Load to $s4, response three cycles after accept, valid held throughout
        MemToReg = 1'b1; instruction = itype(6'h23, 5'd20); alu_result = 32'h0000_0100;
        tick();
        chk("ld_stall_c1", 32'(wb_ready), 32'h0);
        chk("ld_stall_out", 32'(stall), 32'h1);
        tick();
        chk("ld_stall_c2", 32'(wb_ready), 32'h0);
        chk("ld_s4_pending", s[4], 32'h0);
        tick();
        chk("ld_stall_c3", 32'(wb_ready), 32'h0);
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        idle_inputs();
        chk("ld_s4", s[4], 32'h1234_5678);
        chk("ld_ready_back", 32'(wb_ready), 32'h1);
        chk("ld_retire_once", retire_count, 32'd3);
        chk("ld_err", 32'(wr_err), 32'h0);

        // mem_rvalid while idle is ignored
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_0000;
        tick();
        mem_rvalid = 1'b0;
        chk("idle_rvalid_s4", s[4], 32'h1234_5678);
        chk("idle_rvalid_retire", retire_count, 32'd3);

        // Load to $t2 that times out
        wb_valid = 1'b1; RegW = 1'b1; MemToReg = 1'b1; instruction = itype(6'h23, 5'd10);
        tick();
        idle_inputs();
        repeat (15) tick();
        chk("to_still_waiting", 32'(wb_ready), 32'h0);
        chk("to_err_not_yet", 32'(wr_err), 32'h0);
        tick();
        chk("to_idle", 32'(wb_ready), 32'h1);
        chk("to_err", 32'(wr_err), 32'h1);
        chk("to_t2", t[2], 32'h0);
        chk("to_retire", retire_count, 32'd4);

        // Same load with data arriving on the expiry cycle
        do_reset();
        chk("rst_clears_err", 32'(wr_err), 32'h0);
        chk("rst_clears_s1", s[1], 32'h0);
        wb_valid = 1'b1; RegW = 1'b1; MemToReg = 1'b1; instruction = itype(6'h23, 5'd10);
        tick();
        idle_inputs();
        repeat (15) tick();
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0002;
        tick();
        idle_inputs();
        chk("exp_t2", t[2], 32'hCAFE_0002);
        chk("exp_err", 32'(wr_err), 32'h0);
        chk("exp_ready", 32'(wb_ready), 32'h1);
        chk("exp_retire", retire_count, 32'd1);

        // Register 0 discarded silently, register 31 flags an error
        wb_valid = 1'b1; RegW = 1'b1; instruction = rtype(5'd0); alu_result = 32'h77;
        tick();
        chk("rd0_err", 32'(wr_err), 32'h0);
        chk("rd0_retire", retire_count, 32'd2);
        instruction = rtype(5'd31); alu_result = 32'h99;
        tick();
        chk("rd31_err", 32'(wr_err), 32'h1);
        chk("rd31_t2", t[2], 32'hCAFE_0002);
        chk("rd31_s7", s[7], 32'h0);
        chk("rd31_t7", t[7], 32'h0);
        instruction = rtype(5'd8); alu_result = 32'h11;
        tick();
        chk("sticky_t0", t[0], 32'h11);
        chk("sticky_err", 32'(wr_err), 32'h1);
        // RegW=0 retires without writing
        RegW = 1'b0; instruction = rtype(5'd8); alu_result = 32'h22;
        tick();
        idle_inputs();
        chk("nowrite_t0", t[0], 32'h11);
        chk("nowrite_retire", retire_count, 32'd5);

        // Reset mid-load coincident with the memory response
        wb_valid = 1'b1; RegW = 1'b1; MemToReg = 1'b1; instruction = itype(6'h23, 5'd21);
        tick();
        idle_inputs();
        tick();
        rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0BAD;
        tick();
        rst = 1'b0; mem_rvalid = 1'b0;
        chk("rstw_s5", s[5], 32'h0);
        chk("rstw_t0", t[0], 32'h0);
        chk("rstw_ready", 32'(wb_ready), 32'h1);
        chk("rstw_err", 32'(wr_err), 32'h0);
        chk("rstw_retire", retire_count, 32'h0);
        tick();
        chk("rstw_s5_after", s[5], 32'h0);

        // Retire counter wraparound
        chk("wrap_pre", w_retire, 32'hFFFF_FFFF);
        wrap_valid = 1'b1; RegW = 1'b0; instruction = rtype(5'd9);
        tick();
        idle_inputs();
        chk("wrap_post", w_retire, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
